// File: rtl/cla_pkg.sv
// cla_pkg: shared helpers for the pipelined carry-lookahead adder.
// Geometry helpers, saturation limits and parameter legality check.
package cla_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++)
      if ((1 << r) < v) r++;
    return r;
  endfunction

  // Lookahead groups per operand.
  function automatic int g_bits(input int w, input int g);
    return w / g;
  endfunction

  // Operand bits resolved per slice.
  function automatic int st_bits(input int w, input int s);
    return w / s;
  endfunction

  function automatic logic [63:0] sat_max(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] sat_min(input int w);
    return 64'd1 << (w - 1);
  endfunction

  function automatic bit params_ok(input int w, input int g,
                                   input int s);
    return (w > 1) && (g > 0) && (s >= 1) && (w <= 64) &&
           (w % g == 0) && ((w / g) % s == 0);
  endfunction

endpackage

// File: rtl/cla_group.sv
// cla_group: combinational GROUP-bit lookahead adder slice.
// Ports: a, b, cin in; sum, gg (group generate), gp (group propagate), cout out.
module cla_group #(
  parameter int GROUP = 4
) (
  input  logic [GROUP-1:0] a,
  input  logic [GROUP-1:0] b,
  input  logic             cin,
  output logic [GROUP-1:0] sum,
  output logic             gg,
  output logic             gp,
  output logic             cout
);

  logic [GROUP-1:0] g;
  logic [GROUP-1:0] p;
  logic [GROUP:0]   c;

  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c    = '0;
    c[0] = cin;
    gg   = 1'b0;
    for (int i = 0; i < GROUP; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
      gg     = g[i] | (p[i] & gg);
    end
    gp   = &p;
    sum  = p ^ c[GROUP-1:0];
    cout = c[GROUP];
  end

endmodule

// File: rtl/cla_pipe_adder.sv
// cla_pipe_adder: pipelined CLA add/sub, STAGES slices, valid/ready, ovf.
// Ports: clk, rst_n, in_valid/in_ready, a, b, cin, sub,
//   out_valid/out_ready, sum, cout, ovf. Macro CLA_PIPE_SAT_EN: saturate.
module cla_pipe_adder
  import cla_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int GROUP  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int G   = g_bits(WIDTH, GROUP);
  localparam int GPS = G / STAGES;
  localparam int SB  = st_bits(WIDTH, STAGES);

  if (!params_ok(WIDTH, GROUP, STAGES)) begin : g_bad
    $error("cla_pipe_adder: illegal WIDTH/GROUP/STAGES");
  end

  // Index k is the input of slice k; index STAGES is the output slice.
  logic [STAGES:0]            pv;
  logic [STAGES:0]            pc;
  logic [STAGES:0]            rdy;
  logic [STAGES:0][WIDTH-1:0] pa;
  logic [STAGES:0][WIDTH-1:0] pb;
  logic [STAGES:0][WIDTH-1:0] ps;

  logic [G-1:0][GROUP-1:0] gs;
  logic [G-1:0]            gco;

  assign pv[0] = in_valid;
  assign pa[0] = a;
  assign pb[0] = sub ? ~b : b;
  assign pc[0] = sub | cin;
  assign ps[0] = '0;

  always_comb begin
    rdy         = '0;
    rdy[STAGES] = out_ready;
    for (int k = STAGES - 1; k >= 0; k--)
      rdy[k] = !pv[k+1] || rdy[k+1];
  end

  assign in_ready = rdy[0];

  for (genvar j = 0; j < G; j++) begin : g_grp
    localparam int K = j / GPS;
    logic ci;
    logic ggl;
    logic gpl;

    // First group of a slice takes the registered slice carry;
    // later groups chain through the previous group's gg/gp.
    if (j % GPS == 0) begin : g_first
      assign ci = pc[K];
    end else begin : g_chain
      assign ci = g_grp[j-1].ggl |
                  (g_grp[j-1].gpl & g_grp[j-1].ci);
    end

    cla_group #(.GROUP(GROUP)) u_grp (
      .a    (pa[K][j*GROUP +: GROUP]),
      .b    (pb[K][j*GROUP +: GROUP]),
      .cin  (ci),
      .sum  (gs[j]),
      .gg   (ggl),
      .gp   (gpl),
      .cout (gco[j])
    );
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    localparam int L = (k + 1) * GPS - 1;
    logic             v_q;
    logic             c_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] s_q;
    logic [WIDTH-1:0] ns;
    logic             co;

    assign co = g_grp[L].ggl | (g_grp[L].gpl & g_grp[L].ci);

    always_comb begin
      ns = ps[k];
      for (int i = 0; i < GPS; i++)
        ns[k*SB + i*GROUP +: GROUP] = gs[k*GPS + i];
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        a_q <= '0;
        b_q <= '0;
        s_q <= '0;
      end else begin
        if (rdy[k]) v_q <= pv[k];
        if (rdy[k] && pv[k]) begin
          c_q <= co;
          a_q <= pa[k];
          b_q <= pb[k];
          s_q <= ns;
        end
      end
    end

    assign pv[k+1] = v_q;
    assign pc[k+1] = c_q;
    assign pa[k+1] = a_q;
    assign pb[k+1] = b_q;
    assign ps[k+1] = s_q;
  end

  logic             a_msb;
  logic             b_msb;
  logic [WIDTH-1:0] s_last;

  assign a_msb  = pa[STAGES][WIDTH-1];
  assign b_msb  = pb[STAGES][WIDTH-1];
  assign s_last = ps[STAGES];

  assign out_valid = pv[STAGES];
  assign cout      = pc[STAGES];
  // Same-sign operands with a differing result sign is the
  // carry-into-MSB xor carry-out-of-MSB condition.
  assign ovf       = (a_msb == b_msb) && (s_last[WIDTH-1] != a_msb);

`ifdef CLA_PIPE_SAT_EN
  localparam logic [WIDTH-1:0] SMAX = WIDTH'(sat_max(WIDTH));
  localparam logic [WIDTH-1:0] SMIN = WIDTH'(sat_min(WIDTH));
  assign sum = ovf ? (a_msb ? SMIN : SMAX) : s_last;
`else
  assign sum = s_last;
`endif

  logic unused_ok;
  assign unused_ok = ^{gco, pa[STAGES][WIDTH-2:0],
                       pb[STAGES][WIDTH-2:0]};

endmodule

// File: tb/tb_cla_pipe_adder.sv
// tb_cla_pipe_adder: directed and randomized checks of cla_pipe_adder.
// Reference model uses signed/unsigned integer arithmetic.
module tb_cla_pipe_adder;

  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int n_run = 0;
  int n_fail = 0;
  bit rnd_go = 1'b0;
  int rnd_done = 0;

  cla_pipe_adder #(.WIDTH(W), .GROUP(4), .STAGES(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  // Returns {sum, cout, ovf}.
  function automatic logic [W+1:0] model(input logic [W-1:0] x,
                                         input logic [W-1:0] y,
                                         input logic ci,
                                         input logic s);
    int sx, sy, r;
    logic c, o;
    logic [W-1:0] res;
    sx = int'($signed(x));
    sy = int'($signed(y));
    if (s) begin
      r = sx - sy;
      c = (x >= y);
    end else begin
      r = sx + sy + int'(ci);
      c = (int'(x) + int'(y) + int'(ci)) > 65535;
    end
    o = (r > 32767) || (r < -32768);
    res = r[W-1:0];
`ifdef CLA_PIPE_SAT_EN
    if (o) res = (r > 0) ? 16'h7FFF : 16'h8000;
`endif
    return {res, c, o};
  endfunction

  task automatic one_beat(input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic ci, input logic s,
                          output logic [W+1:0] obs, output int lat);
    @(negedge clk);
    a = x; b = y; cin = ci; sub = s;
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    obs = {sum, cout, ovf};
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_run++;
    if ({out_valid, sum, cout, ovf} !== '0) begin
      n_fail++;
      $display("FAIL reset_out: got v=%b s=%h c=%b o=%b want 0",
               out_valid, sum, cout, ovf);
    end
    rst_n = 1'b1;
    #1;
    n_run++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_basic();
    logic [W+1:0] obs, exp;
    int lat;
    exp = model(16'h1234, 16'h4321, 1'b0, 1'b0);
    one_beat(16'h1234, 16'h4321, 1'b0, 1'b0, obs, lat);
    n_run++;
    if (lat !== 2) begin
      n_fail++;
      $display("FAIL basic_latency: got %0d want 2", lat);
    end
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL basic_result: got %h want %h", obs, exp);
    end
    n_run++;
    if (obs !== {16'h5555, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL basic_const: got %h want %h", obs,
               {16'h5555, 2'b00});
    end
    @(negedge clk);
    n_run++;
    if (out_valid !== 1'b0 || sum !== 16'h5555) begin
      n_fail++;
      $display("FAIL basic_hold: got v=%b s=%h want v=0 s=5555",
               out_valid, sum);
    end
  endtask

  task automatic test_carry();
    logic [W+1:0] obs;
    int lat;
    one_beat(16'hFFFF, 16'h0001, 1'b0, 1'b0, obs, lat);
    n_run++;
    if (obs !== {16'h0000, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL carry_ripple: got %h want %h", obs,
               {16'h0000, 2'b10});
    end
    one_beat(16'h00FF, 16'h0000, 1'b1, 1'b0, obs, lat);
    n_run++;
    if (obs !== model(16'h00FF, 16'h0000, 1'b1, 1'b0)) begin
      n_fail++;
      $display("FAIL carry_cin: got %h want %h", obs,
               model(16'h00FF, 16'h0000, 1'b1, 1'b0));
    end
  endtask

  task automatic test_overflow();
    logic [W+1:0] obs;
    int lat;
    logic [W-1:0] ov_add, ov_sub;
`ifdef CLA_PIPE_SAT_EN
    ov_add = 16'h7FFF;
    ov_sub = 16'h8000;
`else
    ov_add = 16'h8000;
    ov_sub = 16'h7FFF;
`endif
    one_beat(16'h7FFF, 16'h0001, 1'b0, 1'b0, obs, lat);
    n_run++;
    if (obs !== {ov_add, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL ovf_add: got %h want %h", obs,
               {ov_add, 2'b01});
    end
    one_beat(16'h8000, 16'h0001, 1'b0, 1'b1, obs, lat);
    n_run++;
    if (obs !== {ov_sub, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL ovf_sub: got %h want %h", obs,
               {ov_sub, 2'b11});
    end
    one_beat(16'h0005, 16'h0007, 1'b1, 1'b1, obs, lat);
    n_run++;
    if (obs !== model(16'h0005, 16'h0007, 1'b1, 1'b1)) begin
      n_fail++;
      $display("FAIL sub_borrow: got %h want %h", obs,
               model(16'h0005, 16'h0007, 1'b1, 1'b1));
    end
  endtask

  task automatic test_stall();
    logic [W+1:0] q[$];
    logic [W+1:0] e;
    logic [W-1:0] xs[6];
    logic [W-1:0] ys[6];
    int sent, got;
    sent = 0;
    got = 0;
    for (int i = 0; i < 6; i++) begin
      xs[i] = W'($urandom);
      ys[i] = W'($urandom);
    end
    for (int t = 0; t < 40 && got < 6; t++) begin
      @(negedge clk);
      out_ready = !(t >= 2 && t <= 5);
      if (sent < 6) begin
        a = xs[sent]; b = ys[sent]; cin = 1'b0; sub = 1'b0;
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (t == 3) begin
        n_run++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
          n_fail++;
          $display("FAIL stall_full: got rdy=%b v=%b want 0 1",
                   in_ready, out_valid);
        end
      end
      if (t == 5) begin
        n_run++;
        if (sent !== 2) begin
          n_fail++;
          $display("FAIL stall_held: got %0d beats want 2", sent);
        end
      end
      if (in_valid && in_ready) begin
        q.push_back(model(xs[sent], ys[sent], 1'b0, 1'b0));
        sent++;
      end
      if (out_valid && out_ready) begin
        n_run++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL stall_spurious: got %h want none", sum);
        end else begin
          e = q.pop_front();
          if ({sum, cout, ovf} !== e) begin
            n_fail++;
            $display("FAIL stall_order: got %h want %h",
                     {sum, cout, ovf}, e);
          end
        end
        got++;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    n_run++;
    if (got !== 6 || q.size() !== 0) begin
      n_fail++;
      $display("FAIL stall_count: got %0d want 6", got);
    end
  endtask

  task automatic test_reset_flight();
    bit stale;
    @(negedge clk);
    out_ready = 1'b0;
    a = 16'h1111; b = 16'h2222; cin = 1'b0; sub = 1'b0;
    in_valid = 1'b1;
    repeat (2) @(negedge clk);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    n_run++;
    if ({out_valid, sum, cout, ovf} !== '0) begin
      n_fail++;
      $display("FAIL flight_reset: got v=%b s=%h want v=0 s=0",
               out_valid, sum);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_run++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL flight_in_ready: got %b want 1", in_ready);
    end
    out_ready = 1'b1;
    stale = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) stale = 1'b1;
    end
    n_run++;
    if (stale !== 1'b0) begin
      n_fail++;
      $display("FAIL flight_stale: got %b want 0", stale);
    end
  endtask

  task automatic test_random();
    rnd_go = 1'b1;
    for (int t = 0; t < 5000 && rnd_done < 3; t++) @(negedge clk);
    n_run++;
    if (rnd_done < 3) begin
      n_fail++;
      $display("FAIL rnd_timeout: got %0d done want 3", rnd_done);
    end
  endtask

  for (genvar i = 0; i < 3; i++) begin : g_rnd
    localparam int RS = (i == 0) ? 1 : (i == 1) ? 4 : 2;
    localparam int RG = (i == 2) ? 4 : 2;
    logic         iv = 1'b0;
    logic         ir;
    logic         ov;
    logic         orr = 1'b0;
    logic         ci = 1'b0;
    logic         sb = 1'b0;
    logic         co;
    logic         of;
    logic [W-1:0] x = '0;
    logic [W-1:0] y = '0;
    logic [W-1:0] s;

    cla_pipe_adder #(.WIDTH(W), .GROUP(RG), .STAGES(RS)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (iv),
      .in_ready  (ir),
      .a         (x),
      .b         (y),
      .cin       (ci),
      .sub       (sb),
      .out_valid (ov),
      .out_ready (orr),
      .sum       (s),
      .cout      (co),
      .ovf       (of)
    );

    initial begin : drv
      logic [W+1:0] q[$];
      logic [W+1:0] e;
      int sent, got;
      bit pend;
      sent = 0;
      got = 0;
      pend = 1'b0;
      wait (rnd_go);
      for (int t = 0; t < 400; t++) begin
        @(negedge clk);
        if (!pend) begin
          if (sent < 150 && t < 300 && $urandom_range(0, 3) != 0) begin
            x = W'($urandom);
            y = W'($urandom);
            ci = 1'($urandom);
            sb = 1'($urandom);
            iv = 1'b1;
            pend = 1'b1;
          end else begin
            iv = 1'b0;
          end
        end
        orr = ($urandom_range(0, 3) != 0) || (t >= 300);
        #1;
        if (iv && ir) begin
          q.push_back(model(x, y, ci, sb));
          sent++;
          pend = 1'b0;
        end
        if (ov && orr) begin
          n_run++;
          if (q.size() == 0) begin
            n_fail++;
            $display("FAIL rnd_spurious cfg%0d: got %h want none",
                     i, s);
          end else begin
            e = q.pop_front();
            if ({s, co, of} !== e) begin
              n_fail++;
              $display("FAIL rnd_result cfg%0d: got %h want %h",
                       i, {s, co, of}, e);
            end
          end
          got++;
        end
      end
      iv = 1'b0;
      n_run++;
      if (q.size() != 0 || got != sent || sent == 0) begin
        n_fail++;
        $display("FAIL rnd_drain cfg%0d: got %0d want %0d",
                 i, got, sent);
      end
      rnd_done++;
    end
  end

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_overflow();
    test_stall();
    test_reset_flight();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
